pet_status_tracker: RTL
=======================

Name: pet_status_tracker

Overview:
- Upstream stage of the LCD character controller. Turns the raw pet buttons (feed, play, sleep) and elapsed time into the values the controller consumes:
  - hunger level (nivel_hambre)
  - fun level (nivel_diversion)
  - glyph-block select (control_signal)
  - ready flag (ready_o)
- Contains input synchronisers and debouncers, a one-second tick generator, decay counters and the pet activity state machine.

Parameters:
TICK_MAX, 50_000_000, clk cycles per one-second tick
DEBOUNCE_MAX, 500_000, cycles a synchronised button must be stable before its debounced value changes
HUNGER_DECAY_S, 10, ticks between automatic hunger-level decrements
FUN_DECAY_S, 8, ticks between automatic fun-level decrements
ANIM_S, 2, ticks spent in EATING/PLAYING before returning to AWAKE
INIT_S, 1, ticks after reset before ready_o rises

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_feed  input  1  raw feed button, active-high, asynchronous to clk
btn_play  input  1  raw play button, active-high, asynchronous
btn_sleep  input  1  raw sleep toggle button, active-high, asynchronous
nivel_hambre  output  3  satiety level, 7 = full, 0 = starving
nivel_diversion  output  3  fun level, 7 = max, 0 = none
control_signal  output  3  glyph block index for the LCD controller
ready_o  output  1  high once outputs are valid; drives ready_i of the LCD controller

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While reset is high, on the next clk edge:
  - nivel_hambre = 7, nivel_diversion = 7, control_signal = 0 (HAPPY), ready_o = 0
  - state = AWAKE; all counters = 0; sync/debounce registers = 0
- Inputs: each button passes through a 2-FF synchroniser, then a debouncer. The debounced value takes the synchronised value after DEBOUNCE_MAX consecutive equal cycles; any mismatch restarts the count. A press is a 1-cycle pulse on the debounced 0→1 edge. Releases generate nothing.
- Tick generator:
  - Free-running counter, 0..TICK_MAX-1; tick pulse is 1 cycle at wrap.
  - Hunger decay counter counts ticks. At HUNGER_DECAY_S it clears and issues hunger_dec. Fun decay works the same with FUN_DECAY_S and fun_dec.
  - Decay counters freeze (hold value) in SLEEPING.
- ready_o: rises after INIT_S ticks following reset, then stays 1 until the next reset. Levels and control_signal are always driven, even while ready_o = 0.
- Level arithmetic, 3-bit, saturating (no wrap):
  - Decrement floors at 0. Increment by 2 saturates at 7.
  - Same-cycle events apply in this order: decay first, then action. Example: hunger 0 with hunger_dec and feed gives 0→0→2; hunger 6 gives 5→7.
  - Feed: hunger += 2.
  - Play: fun += 2, and hunger -= 1 in addition to any decay. Example: hunger 1 with hunger_dec and play ends at 0.
- FSM states: AWAKE, EATING, PLAYING, SLEEPING.
  - AWAKE + feed press → EATING; hunger updated in the same edge.
  - AWAKE + play press (no feed the same cycle) → PLAYING. Feed wins over play; the play press is dropped.
  - AWAKE + sleep press → SLEEPING. Sleep has the lowest priority: if feed or play is pressed the same cycle, the sleep press is dropped.
  - EATING/PLAYING: the animation counter counts ticks. At ANIM_S it returns to AWAKE and the counter clears. All presses are ignored; decay continues.
  - SLEEPING: a sleep press returns to AWAKE. Feed and play are ignored; decay is frozen.
- control_signal is registered and updates on the same edge as the state/level change (1-cycle latency from the press pulse):
  - EATING = 6, PLAYING = 7, SLEEPING = 5
  - AWAKE, evaluated on the next-cycle levels, first match wins:
    1. both levels 0 → 4 (SAD)
    2. hunger ≤ 2 → 2 (HUNGRY)
    3. fun ≤ 2 → 3 (BORED)
    4. both ≥ 5 → 0 (HAPPY)
    5. otherwise → 1 (NEUTRAL)
- Reset mid-animation or mid-debounce: everything returns to reset values on the next edge; a held button must be released and pressed again to count.
- Outputs change at most once per clk edge. The LCD controller samples them asynchronously on its slow clock; with 3-bit registered outputs, single-sample skew is acceptable.

Test Plan:
(All scenarios use TICK_MAX=10, DEBOUNCE_MAX=4, HUNGER_DECAY_S=3, FUN_DECAY_S=2, ANIM_S=2, INIT_S=1.)
- Reset released, no buttons → ready_o = 0 until cycle 10, then 1. Hunger reaches 6 at tick 3 and 5 at tick 6. Fun reaches 6 at tick 2 and 5 at tick 4. control_signal becomes 1 once fun = 4 (hunger still ≥ 5).
- Feed held 3 cycles and released (glitch) → no level change. Feed held 10 cycles from hunger = 4 → hunger 6, control_signal 6 for 2 ticks, then AWAKE face; exactly one increment.
- Feed and play pulses in the same cycle at hunger 3, fun 3 → hunger 5, fun 3 (decay permitting), state EATING. A second feed press during EATING is ignored.
- Play at hunger 1 on a hunger_dec tick → hunger 0, fun += 2, control_signal 7. After ANIM_S ticks: control_signal 2, or 4 if fun has also reached 0.
- Sleep press → control_signal 5; levels unchanged across 20 ticks; feed press ignored. Second sleep press → AWAKE, decay resumes from the frozen counter values.
- Reset asserted during PLAYING with fun = 2 → next edge: levels 7/7, control_signal 0, ready_o 0, state AWAKE.

Source files
------------

// File: rtl/pet_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pet_status_tracker
// Brief    : Conditions the pet buttons, times decay and drives the pet
//            activity FSM that feeds levels and glyph select to the LCD side.
// Revision : 1.0 - initial release
// ============================================================================
module pet_status_tracker #(
    parameter int TICK_MAX       = 50_000_000,
    parameter int DEBOUNCE_MAX   = 500_000,
    parameter int HUNGER_DECAY_S = 10,
    parameter int FUN_DECAY_S    = 8,
    parameter int ANIM_S         = 2,
    parameter int INIT_S         = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_feed,
    input  logic       btn_play,
    input  logic       btn_sleep,
    output logic [2:0] nivel_hambre,
    output logic [2:0] nivel_diversion,
    output logic [2:0] control_signal,
    output logic       ready_o
);

    localparam int TICK_W   = $clog2(TICK_MAX + 1);
    localparam int DB_W     = $clog2(DEBOUNCE_MAX + 1);
    localparam int HUNGER_W = $clog2(HUNGER_DECAY_S + 1);
    localparam int FUN_W    = $clog2(FUN_DECAY_S + 1);
    localparam int ANIM_W   = $clog2(ANIM_S + 1);
    localparam int INIT_W   = $clog2(INIT_S + 1);

    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_MAX - 1);
    localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DEBOUNCE_MAX - 1);
    localparam logic [HUNGER_W-1:0] HUNGER_LAST = HUNGER_W'(HUNGER_DECAY_S - 1);
    localparam logic [FUN_W-1:0]    FUN_LAST    = FUN_W'(FUN_DECAY_S - 1);
    localparam logic [ANIM_W-1:0]   ANIM_LAST   = ANIM_W'(ANIM_S - 1);
    localparam logic [INIT_W-1:0]   INIT_LAST   = INIT_W'(INIT_S - 1);

    localparam logic [2:0] GLYPH_HAPPY   = 3'd0;
    localparam logic [2:0] GLYPH_NEUTRAL = 3'd1;
    localparam logic [2:0] GLYPH_HUNGRY  = 3'd2;
    localparam logic [2:0] GLYPH_BORED   = 3'd3;
    localparam logic [2:0] GLYPH_SAD     = 3'd4;
    localparam logic [2:0] GLYPH_SLEEP   = 3'd5;
    localparam logic [2:0] GLYPH_EAT     = 3'd6;
    localparam logic [2:0] GLYPH_PLAY    = 3'd7;

    typedef enum logic [1:0] {
        AWAKE    = 2'd0,
        EATING   = 2'd1,
        PLAYING  = 2'd2,
        SLEEPING = 2'd3
    } pet_state_t;

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    function automatic logic [2:0] sat_inc2(input logic [2:0] v);
        return (v >= 3'd6) ? 3'd7 : v + 3'd2;
    endfunction

    function automatic logic [2:0] glyph_for(input pet_state_t s,
                                             input logic [2:0] h,
                                             input logic [2:0] f);
        logic [2:0] g;
        case (s)
            EATING:   g = GLYPH_EAT;
            PLAYING:  g = GLYPH_PLAY;
            SLEEPING: g = GLYPH_SLEEP;
            default: begin
                if (h == 3'd0 && f == 3'd0)       g = GLYPH_SAD;
                else if (h <= 3'd2)               g = GLYPH_HUNGRY;
                else if (f <= 3'd2)               g = GLYPH_BORED;
                else if (h >= 3'd5 && f >= 3'd5)  g = GLYPH_HAPPY;
                else                              g = GLYPH_NEUTRAL;
            end
        endcase
        return g;
    endfunction

    // Button conditioning: bit 0 feed, bit 1 play, bit 2 sleep
    logic [2:0] btn_raw;
    logic [2:0] sync_a;
    logic [2:0] sync_b;
    logic [2:0] db;
    logic [2:0] db_d;
    logic [2:0] press;

    assign btn_raw = {btn_sleep, btn_play, btn_feed};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 3'b000;
            sync_b <= 3'b000;
            db_d   <= 3'b000;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            db_d   <= db;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_debounce
            logic [DB_W-1:0] cnt;
            logic            level;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt   <= '0;
                    level <= 1'b0;
                end else if (sync_b[gi] == level) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    cnt   <= '0;
                    level <= sync_b[gi];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign db[gi] = level;
        end
    endgenerate

    assign press = db & ~db_d;

    // Timers, levels and activity FSM
    pet_state_t          state;
    pet_state_t          state_nx;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_cnt_nx;
    logic [HUNGER_W-1:0] hunger_cnt;
    logic [HUNGER_W-1:0] hunger_cnt_nx;
    logic [FUN_W-1:0]    fun_cnt;
    logic [FUN_W-1:0]    fun_cnt_nx;
    logic [ANIM_W-1:0]   anim_cnt;
    logic [ANIM_W-1:0]   anim_cnt_nx;
    logic [INIT_W-1:0]   init_cnt;
    logic [INIT_W-1:0]   init_cnt_nx;
    logic                ready_nx;
    logic [2:0]          hunger_nx;
    logic [2:0]          fun_nx;
    logic [2:0]          control_nx;
    logic                tick;
    logic                frozen;
    logic                hunger_dec;
    logic                fun_dec;

    assign tick       = (tick_cnt == TICK_LAST);
    assign frozen     = (state == SLEEPING);
    assign hunger_dec = tick && !frozen && (hunger_cnt == HUNGER_LAST);
    assign fun_dec    = tick && !frozen && (fun_cnt == FUN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= AWAKE;
            tick_cnt        <= '0;
            hunger_cnt      <= '0;
            fun_cnt         <= '0;
            anim_cnt        <= '0;
            init_cnt        <= '0;
            ready_o         <= 1'b0;
            nivel_hambre    <= 3'd7;
            nivel_diversion <= 3'd7;
            control_signal  <= GLYPH_HAPPY;
        end else begin
            state           <= state_nx;
            tick_cnt        <= tick_cnt_nx;
            hunger_cnt      <= hunger_cnt_nx;
            fun_cnt         <= fun_cnt_nx;
            anim_cnt        <= anim_cnt_nx;
            init_cnt        <= init_cnt_nx;
            ready_o         <= ready_nx;
            nivel_hambre    <= hunger_nx;
            nivel_diversion <= fun_nx;
            control_signal  <= control_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        tick_cnt_nx   = tick ? '0 : tick_cnt + 1'b1;
        hunger_cnt_nx = hunger_cnt;
        fun_cnt_nx    = fun_cnt;
        anim_cnt_nx   = anim_cnt;
        init_cnt_nx   = init_cnt;
        ready_nx      = ready_o;

        if (tick && !frozen) begin
            hunger_cnt_nx = hunger_dec ? '0 : hunger_cnt + 1'b1;
            fun_cnt_nx    = fun_dec    ? '0 : fun_cnt + 1'b1;
        end

        if (tick && !ready_o) begin
            if (init_cnt == INIT_LAST) ready_nx    = 1'b1;
            else                       init_cnt_nx = init_cnt + 1'b1;
        end

        // Decay lands first so a same-edge action works on the decayed level
        hunger_nx = hunger_dec ? sat_dec(nivel_hambre)    : nivel_hambre;
        fun_nx    = fun_dec    ? sat_dec(nivel_diversion) : nivel_diversion;

        case (state)
            AWAKE: begin
                if (press[0]) begin
                    state_nx  = EATING;
                    hunger_nx = sat_inc2(hunger_nx);
                end else if (press[1]) begin
                    state_nx  = PLAYING;
                    fun_nx    = sat_inc2(fun_nx);
                    hunger_nx = sat_dec(hunger_nx);
                end else if (press[2]) begin
                    state_nx = SLEEPING;
                end
            end
            EATING, PLAYING: begin
                if (tick) begin
                    if (anim_cnt == ANIM_LAST) begin
                        anim_cnt_nx = '0;
                        state_nx    = AWAKE;
                    end else begin
                        anim_cnt_nx = anim_cnt + 1'b1;
                    end
                end
            end
            SLEEPING: begin
                if (press[2]) state_nx = AWAKE;
            end
            default: state_nx = AWAKE;
        endcase

        control_nx = glyph_for(state_nx, hunger_nx, fun_nx);
    end

endmodule
`default_nettype wire
